// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (0..MODULUS-1) with load, up/down and registered wrap/reject pulses.
// Latency: one cycle from the enabling ck edge to the updated display and any pulse.
// Backpressure: none; one step per cycle while up or dn is high, loads take effect immediately.
//
// Ports:
//   ck, rst              clock (rising edge) and synchronous active-high reset
//   up, dn               count enables; both high together means hold
//   ld, ld_tens/units    parallel load strobe and BCD digits to load (range checked)
//   display_tens/units   registered BCD count
//   carry, borrow        1-cycle pulses on wrap MODULUS-1 -> 0 and 0 -> MODULUS-1
//   ld_err               1-cycle pulse when a load is rejected
//
// Optional: define BCD_CNT_SAT_EN to saturate at the ends instead of wrapping;
// carry and borrow then stay at 0.
module bcd_mod_counter #(
  parameter int MODULUS   = 24,
  parameter int RESET_VAL = 0
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       up,
  input  logic       dn,
  input  logic       ld,
  input  logic [3:0] ld_tens,
  input  logic [3:0] ld_units,
  output logic [3:0] display_tens,
  output logic [3:0] display_units,
  output logic       carry,
  output logic       borrow,
  output logic       ld_err
);

  // Terminal count and reset value split into digits at elaboration time so
  // the datapath only ever compares and steps 4-bit digits.
  localparam logic [3:0] MAX_TENS  = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] MAX_UNITS = 4'((MODULUS - 1) % 10);
  localparam logic [3:0] RST_TENS  = 4'(RESET_VAL / 10);
  localparam logic [3:0] RST_UNITS = 4'(RESET_VAL % 10);

  logic at_max;
  logic at_zero;
  logic ld_ok;
  logic [3:0] inc_tens, inc_units;
  logic [3:0] dec_tens, dec_units;

  always_comb begin
    at_max  = (display_tens == MAX_TENS) && (display_units == MAX_UNITS);
    at_zero = (display_tens == 4'd0) && (display_units == 4'd0);

    // Digit-wise range check: value < MODULUS  <=>  value <= MODULUS-1.
    ld_ok = (ld_tens <= 4'd9) && (ld_units <= 4'd9) &&
            ((ld_tens < MAX_TENS) ||
             ((ld_tens == MAX_TENS) && (ld_units <= MAX_UNITS)));

    // Non-wrapping step; the wrap cases are handled in the register block.
    if (display_units == 4'd9) begin
      inc_tens  = display_tens + 4'd1;
      inc_units = 4'd0;
    end else begin
      inc_tens  = display_tens;
      inc_units = display_units + 4'd1;
    end

    if (display_units == 4'd0) begin
      dec_tens  = display_tens - 4'd1;
      dec_units = 4'd9;
    end else begin
      dec_tens  = display_tens;
      dec_units = display_units - 4'd1;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      display_tens  <= RST_TENS;
      display_units <= RST_UNITS;
      carry         <= 1'b0;
      borrow        <= 1'b0;
      ld_err        <= 1'b0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      carry  <= 1'b0;
      borrow <= 1'b0;
      ld_err <= 1'b0;
      if (ld) begin
        if (ld_ok) begin
          display_tens  <= ld_tens;
          display_units <= ld_units;
        end else begin
          ld_err <= 1'b1;
        end
      end else if (up && dn) begin
        // Conflicting enables: hold.
      end else if (up) begin
        if (at_max) begin
`ifdef BCD_CNT_SAT_EN
          // Saturate: hold at MODULUS-1.
`else
          display_tens  <= 4'd0;
          display_units <= 4'd0;
          carry         <= 1'b1;
`endif
        end else begin
          display_tens  <= inc_tens;
          display_units <= inc_units;
        end
      end else if (dn) begin
        if (at_zero) begin
`ifdef BCD_CNT_SAT_EN
          // Saturate: hold at 00.
`else
          display_tens  <= MAX_TENS;
          display_units <= MAX_UNITS;
          borrow        <= 1'b1;
`endif
        end else begin
          display_tens  <= dec_tens;
          display_units <= dec_units;
        end
      end
    end
  end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised two-digit BCD modulo counter for the clock datapath. Successor to the fixed 0-23 hours counter.
- One block serves seconds (mod 60), minutes (mod 60) and hours (mod 24), or any modulus from 2 to 100.
- Adds synchronous reset, down-counting, parallel load with range checking, and registered carry/borrow pulses, so stages chain without glue logic.

Parameters:
- MODULUS, 24, count range 0..MODULUS-1; legal 2..100.
- RESET_VAL, 0, value loaded on reset; must be < MODULUS.

Ports:
- ck  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- up  input  1  increment enable, one step per cycle while high
- dn  input  1  decrement enable, one step per cycle while high
- ld  input  1  parallel load strobe
- ld_tens  input  4  BCD tens digit for load
- ld_units  input  4  BCD units digit for load
- display_tens  output  4  registered BCD tens digit
- display_units  output  4  registered BCD units digit
- carry  output  1  registered 1-cycle pulse on wrap MODULUS-1 -> 0
- borrow  output  1  registered 1-cycle pulse on wrap 0 -> MODULUS-1
- ld_err  output  1  registered 1-cycle pulse when a load is rejected

Behaviour:
- Reset: synchronous on a rising ck edge with rst=1.
  - Digits take the tens/units of RESET_VAL.
  - carry, borrow and ld_err are 0.
  - rst overrides every other input.
- Priority per edge: rst > ld > (up & dn) > up > dn > hold.
- Load (ld=1):
  - Accepted only if both digits are 0..9 and 10*ld_tens+ld_units < MODULUS. The value appears on the display the next cycle.
  - Rejected otherwise: the digits hold and ld_err=1 for one cycle.
  - up and dn are ignored in a load cycle. No carry or borrow is generated.
- up=1, dn=1 together with ld=0: hold. No pulses.
- Increment:
  - At MODULUS-1: go to 00 and set carry=1 in the same cycle the display shows 00.
  - Else if units=9: units=0, tens+1.
  - Else: units+1.
- Decrement:
  - At 00: go to MODULUS-1 and set borrow=1 in the same cycle the display shows MODULUS-1.
  - Else if units=0: units=9, tens-1.
  - Else: units-1.
- Latency: exactly one cycle from an enabling edge to the updated display and pulse.
- Pulses last exactly one cycle. Each is deasserted on every cycle with no wrap, reject or reset.
- Illegal internal digit values (>9) are never produced. All arithmetic is on 4-bit digits; there is no binary intermediate.
- Continuous up holding high for MODULUS cycles returns the counter to its start value with exactly one carry.
- Reset mid-count aborts any pending pulse: the outputs are 0 in the cycle after the reset edge.
- Chaining: the carry of one stage drives the up of the next. The next stage steps one cycle after the wrap, which is accepted system latency.

Optional Feature:
- Macro BCD_CNT_SAT_EN.
- Defined: the counter saturates.
  - Increment at MODULUS-1 holds the value and raises no carry.
  - Decrement at 00 holds the value and raises no borrow.
  - carry/borrow stay tied to 0.
- Undefined: the wrap-around behaviour above, with carry and borrow pulses.

Test Plan:
- MODULUS=24, rst 1 cycle, then up=1 for 24 cycles:
  - After reset: display 0,0.
  - Display sequence: 00..09, 10..19, 20..23, then 00.
  - carry=1 only in the cycle showing 00 after 23.
- MODULUS=60, load 5,9 then up=1 one cycle -> display 0,0, carry=1 for one cycle. Then dn=1 one cycle -> display 5,9, borrow=1 for one cycle.
- MODULUS=24 load tests:
  - Load 2,4 -> rejected, display holds, ld_err=1 one cycle.
  - Load 1,10 -> rejected, ld_err=1.
  - Load 1,9 -> accepted, display 1,9, ld_err=0.
- Simultaneous events:
  - At 1,5 with up=dn=1 -> holds 1,5.
  - ld=1 (0,7) with up=1 -> display 0,7, no carry.
  - rst=1 with ld=1 -> display equals RESET_VAL.
- Reset mid-wrap: MODULUS=24 at 23, up=1 and rst=1 on the same edge -> display 0,0, carry=0.
- BCD_CNT_SAT_EN defined, MODULUS=60:
  - At 59 with up=1 for 3 cycles -> stays 5,9, carry never asserted.
  - At 00 with dn=1 -> stays 0,0, borrow never asserted.
